// File: rtl/serial_rx_pkg.sv
// Shared types and width helpers for the serial register-bank receiver.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    RECV = 2'd2
  } rx_state_e;

  function automatic int unsigned frame_w(input int unsigned addr_w,
                                          input int unsigned data_w,
                                          input int unsigned parity_en);
    return addr_w + data_w + parity_en;
  endfunction

  function automatic int unsigned pkt_cnt_w(input int unsigned num_pkt);
    return $clog2(num_pkt + 1);
  endfunction

endpackage

// File: rtl/serial_deframer.sv
// Serial shift register, saturating bit counter and running parity for one frame.
module serial_deframer #(
  parameter int unsigned FRAME_W   = 21,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_first,
  input  logic               i_shift,
  input  logic               i_active,
  input  logic               i_sen,
  input  logic               i_sd,
  output logic               o_frame_end_c,
  output logic               o_len_ok_c,
  output logic               o_par_ok_c,
  output logic [FRAME_W-1:0] o_word
);

  localparam int unsigned CNT_W = $clog2(FRAME_W + 2);

  logic [FRAME_W-1:0] r_shreg;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_par;

  // First bit restarts the frame; later bits shift in, counter sticks one past a full frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
    end else if (i_first) begin
      r_shreg   <= FRAME_W'(i_sd);
      r_bit_cnt <= CNT_W'(1);
      r_par     <= i_sd;
    end else if (i_shift) begin
      r_shreg <= {r_shreg[FRAME_W-2:0], i_sd};
      r_par   <= r_par ^ i_sd;
      if (r_bit_cnt != CNT_W'(FRAME_W + 1)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  assign o_frame_end_c = i_active & i_sen;
  assign o_len_ok_c    = (r_bit_cnt == CNT_W'(FRAME_W));
  assign o_par_ok_c    = (PARITY_EN == 0) || !r_par;
  assign o_word        = r_shreg;

endmodule

// File: rtl/serial_rb_rx.sv
// Serial-to-register-bank receiver: frame FSM, write/error strobes and group counter.
module serial_rb_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned NUM_PKT   = 8,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sen,
  input  logic                          sd,
  output logic                          RB_RW,
  output logic [ADDR_W-1:0]             RB_A,
  output logic [DATA_W-1:0]             RB_D,
  output logic                          rx_done,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic [pkt_cnt_w(NUM_PKT)-1:0] pkt_cnt
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W, PARITY_EN);
  localparam int unsigned CNT_W   = pkt_cnt_w(NUM_PKT);

  rx_state_e          r_state;
  rx_state_e          w_next_state;
  logic               w_first;
  logic               w_shift;
  logic               w_wr;
  logic               w_ferr;
  logic               w_perr;
  logic               w_frame_end;
  logic               w_len_ok;
  logic               w_par_ok;
  logic [FRAME_W-1:0] w_word;

  serial_deframer #(
    .FRAME_W  (FRAME_W),
    .PARITY_EN(PARITY_EN)
  ) u_deframer (
    .clk          (clk),
    .rst          (rst),
    .i_first      (w_first),
    .i_shift      (w_shift),
    .i_active     (r_state == RECV),
    .i_sen        (sen),
    .i_sd         (sd),
    .o_frame_end_c(w_frame_end),
    .o_len_ok_c   (w_len_ok),
    .o_par_ok_c   (w_par_ok),
    .o_word       (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= SYNC;
    else     r_state <= w_next_state;
  end

  // SYNC waits for an idle sen so a frame cut by reset is never evaluated.
  always_comb begin
    w_next_state = r_state;
    w_first      = 1'b0;
    w_shift      = 1'b0;
    w_wr         = 1'b0;
    w_ferr       = 1'b0;
    w_perr       = 1'b0;
    unique case (r_state)
      SYNC: if (sen) w_next_state = IDLE;
      IDLE: begin
        if (!sen) begin
          w_next_state = RECV;
          w_first      = 1'b1;
        end
      end
      RECV: begin
        if (w_frame_end) begin
          w_next_state = IDLE;
          if (!w_len_ok)      w_ferr = 1'b1;
          else if (!w_par_ok) w_perr = 1'b1;
          else                w_wr   = 1'b1;
        end else begin
          w_shift = 1'b1;
        end
      end
      default: w_next_state = SYNC;
    endcase
  end

  // Strobes last one cycle; address/data hold until the next accepted frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      RB_RW      <= 1'b1;
      RB_A       <= '0;
      RB_D       <= '0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      RB_RW      <= ~w_wr;
      frame_err  <= w_ferr;
      parity_err <= w_perr;
      rx_done    <= 1'b0;
      if (w_wr) begin
        RB_A <= w_word[PARITY_EN+DATA_W +: ADDR_W];
        RB_D <= w_word[PARITY_EN +: DATA_W];
        if (pkt_cnt == CNT_W'(NUM_PKT - 1)) begin
          pkt_cnt <= '0;
          rx_done <= 1'b1;
        end else begin
          pkt_cnt <= pkt_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rb_rx.sv
// Directed bench for serial_rb_rx: default, parity-enabled and narrow 4/8/3 instances.
module tb_serial_rb_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] sen_v;
  logic [2:0] sd_v;

  logic        rw0, done0, fe0, pe0;
  logic [2:0]  a0;
  logic [17:0] d0;
  logic [3:0]  cnt0;
  logic        rw1, done1, fe1, pe1;
  logic [2:0]  a1;
  logic [17:0] d1;
  logic [3:0]  cnt1;
  logic        rw2, done2, fe2, pe2;
  logic [3:0]  a2;
  logic [7:0]  d2;
  logic [1:0]  cnt2;

  serial_rb_rx u_def (
    .clk(clk), .rst(rst), .sen(sen_v[0]), .sd(sd_v[0]),
    .RB_RW(rw0), .RB_A(a0), .RB_D(d0), .rx_done(done0),
    .frame_err(fe0), .parity_err(pe0), .pkt_cnt(cnt0)
  );

  serial_rb_rx #(.PARITY_EN(1)) u_par (
    .clk(clk), .rst(rst), .sen(sen_v[1]), .sd(sd_v[1]),
    .RB_RW(rw1), .RB_A(a1), .RB_D(d1), .rx_done(done1),
    .frame_err(fe1), .parity_err(pe1), .pkt_cnt(cnt1)
  );

  serial_rb_rx #(.ADDR_W(4), .DATA_W(8), .NUM_PKT(3)) u_small (
    .clk(clk), .rst(rst), .sen(sen_v[2]), .sd(sd_v[2]),
    .RB_RW(rw2), .RB_A(a2), .RB_D(d2), .rx_done(done2),
    .frame_err(fe2), .parity_err(pe2), .pkt_cnt(cnt2)
  );

  logic [2:0]  mon_rw, mon_done, mon_fe, mon_pe;
  logic [31:0] mon_a [3];
  logic [31:0] mon_d [3];
  logic [31:0] mon_cnt [3];

  assign mon_rw   = {rw2, rw1, rw0};
  assign mon_done = {done2, done1, done0};
  assign mon_fe   = {fe2, fe1, fe0};
  assign mon_pe   = {pe2, pe1, pe0};
  assign mon_a[0] = 32'(a0);
  assign mon_a[1] = 32'(a1);
  assign mon_a[2] = 32'(a2);
  assign mon_d[0] = 32'(d0);
  assign mon_d[1] = 32'(d1);
  assign mon_d[2] = 32'(d2);
  assign mon_cnt[0] = 32'(cnt0);
  assign mon_cnt[1] = 32'(cnt1);
  assign mon_cnt[2] = 32'(cnt2);

  int n_chk  = 0;
  int n_fail = 0;
  int n_wr [3];
  int n_evt0 = 0;

  initial begin
    for (int u = 0; u < 3; u++) n_wr[u] = 0;
  end

  // Strobe-cycle counters catch strobes that last more than one cycle or appear unasked.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) if (!mon_rw[u]) n_wr[u] = n_wr[u] + 1;
    if (!rw0 || fe0 || pe0) n_evt0 = n_evt0 + 1;
  end

  typedef struct {
    int          u;
    logic [63:0] bits;
    int          n;
    logic        rw;
    logic        fe;
    logic        pe;
    logic        done;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge inside cycle E+1.
  task automatic send(input int u, input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sen_v[u] = 1'b0;
      sd_v[u]  = bits[i];
      @(negedge clk);
    end
    sen_v[u] = 1'b1;
    sd_v[u]  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int evt_before;
    rst   = 1'b1;
    sen_v = 3'b111;
    sd_v  = 3'b000;

    for (int k = 0; k < 24; k++)
      tv.push_back('{0, 64'({3'(k), 18'(18'h2A000 + k)}), 21, 1'b0, 1'b0, 1'b0,
                     1'((k % 8) == 7), 32'(k % 8), 32'(18'h2A000 + k), 32'((k + 1) % 8)});
    tv.push_back('{0, 64'h000ABCDE, 20, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'h2A017, 32'd0});
    tv.push_back('{0, 64'h005A5A5A, 23, 1'b1, 1'b1, 1'b0, 1'b0, 32'd7, 32'h2A017, 32'd0});
    tv.push_back('{0, 64'({3'd2, 18'h12345}), 21, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2, 32'h12345, 32'd1});
    tv.push_back('{1, 64'({3'b101, 18'h00001, 1'b0}), 22, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0});
    tv.push_back('{1, 64'({3'b101, 18'h00001, 1'b1}), 22, 1'b0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd1, 32'd1});
    tv.push_back('{1, 64'({3'd0, 18'h00000, 1'b0}), 22, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd2});
    tv.push_back('{2, 64'h0A5C, 12, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA, 32'h5C, 32'd1});
    tv.push_back('{2, 64'h0123, 12, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h23, 32'd2});
    tv.push_back('{2, 64'h0FFF, 12, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF, 32'hFF, 32'd0});

    repeat (2) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("reset_rw_u%0d", u), 64'(mon_rw[u]), 64'd1);
      chk($sformatf("reset_a_u%0d", u), 64'(mon_a[u]), 64'd0);
      chk($sformatf("reset_d_u%0d", u), 64'(mon_d[u]), 64'd0);
      chk($sformatf("reset_cnt_u%0d", u), 64'(mon_cnt[u]), 64'd0);
      chk($sformatf("reset_pulses_u%0d", u), 64'({mon_done[u], mon_fe[u], mon_pe[u]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    foreach (tv[i]) begin
      send(tv[i].u, tv[i].bits, tv[i].n);
      chk($sformatf("v%0d_rw", i), 64'(mon_rw[tv[i].u]), 64'(tv[i].rw));
      chk($sformatf("v%0d_ferr", i), 64'(mon_fe[tv[i].u]), 64'(tv[i].fe));
      chk($sformatf("v%0d_perr", i), 64'(mon_pe[tv[i].u]), 64'(tv[i].pe));
      chk($sformatf("v%0d_done", i), 64'(mon_done[tv[i].u]), 64'(tv[i].done));
      chk($sformatf("v%0d_addr", i), 64'(mon_a[tv[i].u]), 64'(tv[i].a));
      chk($sformatf("v%0d_data", i), 64'(mon_d[tv[i].u]), 64'(tv[i].d));
      chk($sformatf("v%0d_cnt", i), 64'(mon_cnt[tv[i].u]), 64'(tv[i].cnt));
    end
    @(negedge clk);
    chk("after_table_rw_idle", 64'(rw0), 64'd1);

    // Reset lands after 10 bits while sen stays low for 11 more cycles.
    evt_before = n_evt0;
    for (int i = 0; i < 10; i++) begin
      sen_v[0] = 1'b0;
      sd_v[0]  = 1'(i & 1);
      @(negedge clk);
    end
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      sen_v[0] = 1'b0;
      sd_v[0]  = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    sen_v[0] = 1'b1;
    sd_v[0]  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_events", 64'(n_evt0 - evt_before), 64'd0);
    chk("abort_cnt_cleared", 64'(cnt0), 64'd0);
    chk("abort_addr_cleared", 64'(a0), 64'd0);

    send(0, 64'({3'd6, 18'h3FFFF}), 21);
    chk("post_reset_rw", 64'(rw0), 64'd0);
    chk("post_reset_addr", 64'(a0), 64'd6);
    chk("post_reset_data", 64'(d0), 64'h3FFFF);
    chk("post_reset_cnt", 64'(cnt0), 64'd1);
    @(negedge clk);
    chk("post_reset_rw_release", 64'(rw0), 64'd1);
    chk("post_reset_addr_hold", 64'(a0), 64'd6);
    chk("post_reset_data_hold", 64'(d0), 64'h3FFFF);

    chk("strobe_cycles_u0", 64'(n_wr[0]), 64'd26);
    chk("strobe_cycles_u1", 64'(n_wr[1]), 64'd2);
    chk("strobe_cycles_u2", 64'(n_wr[2]), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
